// File: rtl/frontend_pkg.sv
// Shared frontend types: the fetch-queue entry, the realign drain states and
// the RVC parcel test.
package frontend_pkg;

  localparam int unsigned FE_VLEN = 32;

  typedef struct packed {
    logic [FE_VLEN-1:0] addr;
    logic [31:0]        data;
  } fetch_entry_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } drain_state_e;

  // A parcel whose two low bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_rvc(logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_realign_drain.sv
// Pops 32-bit fetch words, splits them into 16-bit parcels and rebuilds RVC and
// word-straddling 32-bit instructions into a registered valid/ready output slot.
module instr_realign_drain
  import frontend_pkg::*;
#(
  parameter int unsigned VLEN = 32,
  parameter bit          RVC  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic [VLEN+31:0] fifo_data_i,
  output logic             fifo_pop_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic [VLEN-1:0]  pc_o,
  output logic             is_compressed_o,
  output drain_state_e     state_o
);

  // Output slot handshake: instr_valid_o/instr_o/pc_o/is_compressed_o form one
  // registered slot. It transfers on a clock edge where instr_valid_o and
  // instr_ready_i are both high; while valid is high and ready is low the slot
  // holds every field. The slot may be (re)loaded whenever it is empty or being
  // taken in the same cycle (w_adv); nothing is popped or loaded otherwise.

  drain_state_e    r_state;
  logic [15:0]     r_half;
  logic [VLEN-1:0] r_half_pc;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [VLEN-1:0] r_pc;
  logic            r_is_c;

  drain_state_e    w_state_d;
  logic            w_adv;
  logic [VLEN-1:0] w_addr;
  logic [15:0]     w_lo;
  logic [15:0]     w_hi;
  logic            w_pop;
  logic            w_load;
  logic [31:0]     w_ld_instr;
  logic [VLEN-1:0] w_ld_pc;
  logic            w_ld_c;
  logic            w_half_we;
  logic [15:0]     w_half_d;
  logic [VLEN-1:0] w_half_pc_d;

  assign w_adv  = ~r_valid | instr_ready_i;
  assign w_addr = fifo_data_i[VLEN+31:32];
  assign w_lo   = fifo_data_i[15:0];
  assign w_hi   = fifo_data_i[31:16];

  always_comb begin
    w_state_d   = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_ld_instr  = '0;
    w_ld_pc     = '0;
    w_ld_c      = 1'b0;
    w_half_we   = 1'b0;
    w_half_d    = r_half;
    w_half_pc_d = r_half_pc;

    unique case (r_state)
      EMPTY: begin
        if (w_adv && !fifo_empty_i) begin
          w_pop = 1'b1;
          if (!RVC) begin
            // Without RVC an odd-halfword entry carries nothing to decode.
            if (!w_addr[1]) begin
              w_load     = 1'b1;
              w_ld_instr = fifo_data_i[31:0];
              w_ld_pc    = w_addr;
            end
          end else if (!w_addr[1]) begin
            if (is_rvc(w_lo)) begin
              w_load      = 1'b1;
              w_ld_instr  = {16'h0000, w_lo};
              w_ld_pc     = w_addr;
              w_ld_c      = 1'b1;
              w_half_we   = 1'b1;
              w_half_d    = w_hi;
              w_half_pc_d = w_addr + VLEN'(2);
              w_state_d   = HALF;
            end else begin
              w_load     = 1'b1;
              w_ld_instr = fifo_data_i[31:0];
              w_ld_pc    = w_addr;
            end
          end else begin
            if (is_rvc(w_hi)) begin
              w_load     = 1'b1;
              w_ld_instr = {16'h0000, w_hi};
              w_ld_pc    = w_addr;
              w_ld_c     = 1'b1;
            end else begin
              w_half_we   = 1'b1;
              w_half_d    = w_hi;
              w_half_pc_d = w_addr;
              w_state_d   = HALF;
            end
          end
        end
      end

      HALF: begin
        if (is_rvc(r_half)) begin
          if (w_adv) begin
            w_load     = 1'b1;
            w_ld_instr = {16'h0000, r_half};
            w_ld_pc    = r_half_pc;
            w_ld_c     = 1'b1;
            w_state_d  = EMPTY;
          end
        end else if (!fifo_empty_i) begin
          if (w_addr == r_half_pc + VLEN'(2)) begin
            if (w_adv) begin
              w_pop       = 1'b1;
              w_load      = 1'b1;
              w_ld_instr  = {w_lo, r_half};
              w_ld_pc     = r_half_pc;
              w_half_we   = 1'b1;
              w_half_d    = w_hi;
              w_half_pc_d = r_half_pc + VLEN'(4);
            end
          end else begin
            // Redirected stream: the stale upper half can never complete.
            w_state_d = EMPTY;
          end
        end
      end

      default: w_state_d = EMPTY;
    endcase

    if (flush_i) begin
      w_pop     = 1'b0;
      w_load    = 1'b0;
      w_half_we = 1'b0;
      w_state_d = EMPTY;
    end
  end

  assign fifo_pop_o = w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= EMPTY;
      r_half    <= '0;
      r_half_pc <= '0;
    end else begin
      r_state <= w_state_d;
      if (flush_i) begin
        r_half    <= '0;
        r_half_pc <= '0;
      end else if (w_half_we) begin
        r_half    <= w_half_d;
        r_half_pc <= w_half_pc_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_is_c  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_is_c  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_instr <= w_ld_instr;
      r_pc    <= w_ld_pc;
      r_is_c  <= w_ld_c;
    end else if (instr_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign instr_valid_o   = r_valid;
  assign instr_o         = r_instr;
  assign pc_o            = r_pc;
  assign is_compressed_o = r_is_c;
  assign state_o         = r_state;

endmodule

// File: tb/tb_instr_realign_drain.sv
// Bench for instr_realign_drain: a fetch-queue model feeds words, a scoreboard
// of expected {compressed, pc, instr} is checked on every output handshake.
module tb_instr_realign_drain;
  import frontend_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         fifo_empty;
  logic [63:0]  fifo_data;
  logic         fifo_pop;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  pc;
  logic         is_c;
  drain_state_e state;

  fetch_entry_t fifo_q[$];
  logic [64:0]  exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           pop_cnt = 0;
  logic         pop_s;

  instr_realign_drain #(.VLEN(32), .RVC(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_pop_o(fifo_pop),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .instr_o(instr),
    .pc_o(pc), .is_compressed_o(is_c), .state_o(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 64'h0 : {fifo_q[0].addr, fifo_q[0].data};
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    fetch_entry_t e;
    e.addr = a;
    e.data = d;
    fifo_q.push_back(e);
    drive_fifo();
  endtask

  task automatic expect_instr(input logic c, input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back({c, p, i});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget, input bit rnd_ready);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || instr_valid) && k < budget) begin
      if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    instr_ready = 1'b1;
    n_vec++;
    if (exp_q.size() != 0 || fifo_q.size() != 0 || instr_valid) begin
      n_err++;
      $display("FAIL drain_timeout: exp left=%0d fifo left=%0d valid=%0b, required all 0",
               exp_q.size(), fifo_q.size(), instr_valid);
    end
  endtask

  // ---------------- fetch queue model + scoreboard ----------------
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      pop_s = fifo_pop;
      if (rst_n && pop_s) begin
        n_vec++;
        if (fifo_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_on_empty: fifo_pop_o=1 with empty queue, required 0");
        end
      end
      if (rst_n && instr_valid && instr_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_instr: got c=%0b pc=%h instr=%h, required no output",
                   is_c, pc, instr);
        end else begin
          e = exp_q.pop_front();
          if ({is_c, pc, instr} !== e) begin
            n_err++;
            $display("FAIL slot: got c=%0b pc=%h instr=%h, required c=%0b pc=%h instr=%h",
                     is_c, pc, instr, e[64], e[63:32], e[31:0]);
          end
        end
      end
      @(posedge clk);
      #1;
      if (rst_n && pop_s && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      drive_fifo();
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_vec++;
    if ({instr_valid, instr, pc, is_c, fifo_pop} !== 67'h0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%0b instr=%h pc=%h c=%0b pop=%0b, required all 0",
               instr_valid, instr, pc, is_c, fifo_pop);
    end
    n_vec++;
    if (state !== EMPTY) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required EMPTY", state);
    end
  endtask

  task automatic test_words();
    int p0 = pop_cnt;
    instr_ready = 1'b1;
    expect_instr(1'b0, 32'h0, 32'h0000_0013);
    expect_instr(1'b0, 32'h4, 32'h0010_0093);
    push_word(32'h0, 32'h0000_0013);
    push_word(32'h4, 32'h0010_0093);
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b1 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL words_cycle0: pop=%0b valid=%0b, required pop=1 valid=0", fifo_pop, instr_valid);
    end
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b1 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL words_cycle1: pop=%0b valid=%0b, required pop=1 valid=1", fifo_pop, instr_valid);
    end
    wait_drain(50, 1'b0);
    n_vec++;
    if (pop_cnt - p0 != 2) begin
      n_err++;
      $display("FAIL words_pops: got %0d, required 2", pop_cnt - p0);
    end
  endtask

  task automatic test_rvc_pair();
    int p0 = pop_cnt;
    expect_instr(1'b1, 32'h0, 32'h0000_4501);
    expect_instr(1'b1, 32'h2, 32'h0000_0001);
    push_word(32'h0, 32'h0001_4501);
    wait_drain(50, 1'b0);
    n_vec++;
    if (pop_cnt - p0 != 1) begin
      n_err++;
      $display("FAIL rvc_pair_pops: got %0d, required 1", pop_cnt - p0);
    end
  endtask

  task automatic test_straddle();
    int p0 = pop_cnt;
    expect_instr(1'b1, 32'h0, 32'h0000_4501);
    expect_instr(1'b0, 32'h2, 32'h0010_0093);
    expect_instr(1'b1, 32'h6, 32'h0000_0000);
    push_word(32'h0, 32'h0093_4501);
    push_word(32'h4, 32'h0000_0010);
    wait_drain(50, 1'b0);
    n_vec++;
    if (pop_cnt - p0 != 2 || state !== EMPTY) begin
      n_err++;
      $display("FAIL straddle_end: pops=%0d state=%0d, required pops=2 state=EMPTY",
               pop_cnt - p0, state);
    end
  endtask

  task automatic test_discontinuity();
    push_word(32'h6, 32'h2083_0000);
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b1) begin
      n_err++;
      $display("FAIL disc_pop_first: got %0b, required 1", fifo_pop);
    end
    step();
    step();
    step();
    n_vec++;
    if (state !== HALF || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL disc_wait: state=%0d valid=%0b, required HALF and 0", state, instr_valid);
    end
    expect_instr(1'b0, 32'h40, 32'h0000_0013);
    push_word(32'h40, 32'h0000_0013);
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b0 || state !== HALF) begin
      n_err++;
      $display("FAIL disc_drop: pop=%0b state=%0d, required pop=0 state=HALF", fifo_pop, state);
    end
    step();
    n_vec++;
    if (state !== EMPTY || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL disc_bubble: state=%0d valid=%0b, required EMPTY and 0", state, instr_valid);
    end
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b1) begin
      n_err++;
      $display("FAIL disc_resume_pop: got %0b, required 1", fifo_pop);
    end
    wait_drain(50, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] i_h;
    logic [31:0] p_h;
    int k = 0;
    instr_ready = 1'b0;
    expect_instr(1'b0, 32'h100, 32'h0000_0013);
    expect_instr(1'b0, 32'h104, 32'h0010_0093);
    push_word(32'h100, 32'h0000_0013);
    push_word(32'h104, 32'h0010_0093);
    while (!instr_valid && k < 10) begin
      step();
      k++;
    end
    i_h = instr;
    p_h = pc;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== 32'h0000_0013 || pc !== 32'h100 ||
          instr !== i_h || pc !== p_h || fifo_pop !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: valid=%0b instr=%h pc=%h pop=%0b, required 1 00000013 00000100 0",
                 c, instr_valid, instr, pc, fifo_pop);
      end
    end
    step();
    instr_ready = 1'b1;
    step();
    n_vec++;
    if (instr_valid !== 1'b1 || pc !== 32'h104) begin
      n_err++;
      $display("FAIL release_next: valid=%0b pc=%h, required 1 00000104", instr_valid, pc);
    end
    wait_drain(50, 1'b0);
  endtask

  task automatic gen_stream(input logic [31:0] start, input int n);
    logic [15:0] par_q[$];
    logic [31:0] p = start;
    logic [15:0] c;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = 16'($urandom);
        c[1:0] = 2'($urandom_range(0, 2));
        par_q.push_back(c);
        expect_instr(1'b1, p, {16'h0000, c});
        p = p + 32'd2;
      end else begin
        w = $urandom;
        w[1:0] = 2'b11;
        par_q.push_back(w[15:0]);
        par_q.push_back(w[31:16]);
        expect_instr(1'b0, p, w);
        p = p + 32'd4;
      end
    end
    if (par_q.size() % 2 == 1) begin
      par_q.push_back(16'h0001);
      expect_instr(1'b1, p, 32'h0000_0001);
    end
    for (int k = 0; k < par_q.size() / 2; k++)
      push_word(start + 32'(4 * k), {par_q[2*k+1], par_q[2*k]});
  endtask

  task automatic test_random();
    gen_stream(32'h0000_1000, 60);
    wait_drain(3000, 1'b1);
    gen_stream(32'hFFFF_FFF0, 40);
    wait_drain(3000, 1'b1);
  endtask

  task automatic test_flush();
    instr_ready = 1'b0;
    expect_instr(1'b1, 32'h200, 32'h0000_4501);
    push_word(32'h200, 32'h0093_4501);
    step();
    step();
    n_vec++;
    if (state !== HALF || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_setup: state=%0d valid=%0b, required HALF and 1", state, instr_valid);
    end
    push_word(32'h204, 32'h0000_0010);
    flush = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pop: got %0b, required 0", fifo_pop);
    end
    step();
    n_vec++;
    if (instr_valid !== 1'b0 || state !== EMPTY || instr !== 32'h0 || pc !== 32'h0) begin
      n_err++;
      $display("FAIL flush_clear: valid=%0b state=%0d instr=%h pc=%h, required 0 EMPTY 0 0",
               instr_valid, state, instr, pc);
    end
    flush = 1'b0;
    fifo_q.delete();
    drive_fifo();
    step();
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    push_word(32'h300, 32'h0000_0013);
    push_word(32'h304, 32'h0093_4501);
    expect_instr(1'b0, 32'h300, 32'h0000_0013);
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({instr_valid, instr, pc, is_c} !== 66'h0 || state !== EMPTY) begin
      n_err++;
      $display("FAIL async_reset: valid=%0b instr=%h pc=%h c=%0b state=%0d, required all 0/EMPTY",
               instr_valid, instr, pc, is_c, state);
    end
    exp_q.delete();
    fifo_q.delete();
    drive_fifo();
    step();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    step();
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b0;
    drive_fifo();
    test_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    test_reset();
    step();
    test_words();
    test_rvc_pair();
    test_straddle();
    test_discontinuity();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    test_words();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
